// File: rtl/collision_sequencer.sv
// Collision sequencer: captures per-pair collision flags, grants one pair at a
// time to the velocity resolver in round-robin order, waits for the resolver's
// acknowledge (or times out), and then enforces a short settle gap. Each pair
// is resolved at most once per frame.
module collision_sequencer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [9:0] colVec,
  input  logic       resolveAck,
  output logic       resolveReq,
  output logic [3:0] pairIdx,
  output logic [2:0] ballA,
  output logic [2:0] ballB,
  output logic [9:0] servedMask,
  output logic [3:0] pendingCount,
  output logic       busy,
  output logic       timeoutErr
);

  // Counters are sized to hold their full parameter value without wrapping.
  localparam int WAIT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  // Count value on the last cycle of each phase; a zero-length settle still
  // spends one cycle in SETTLE.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES < 1) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [9:0]          pending;
  logic [9:0]          pending_next;
  logic [9:0]          clear_mask;
  logic [3:0]          last_grant;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                grant_found;
  logic [3:0]          grant_idx;
  logic [4:0]          cand;
  logic                req_done;
  logic                timeout_hit;
  logic                settle_done;

  // Lower/higher ball numbers of each pair, packed as {ballA, ballB}.
  function automatic logic [5:0] pair_balls(input logic [3:0] idx);
    case (idx)
      4'd0:    return {3'd0, 3'd1};
      4'd1:    return {3'd0, 3'd2};
      4'd2:    return {3'd0, 3'd3};
      4'd3:    return {3'd0, 3'd4};
      4'd4:    return {3'd1, 3'd2};
      4'd5:    return {3'd1, 3'd3};
      4'd6:    return {3'd1, 3'd4};
      4'd7:    return {3'd2, 3'd3};
      4'd8:    return {3'd2, 3'd4};
      4'd9:    return {3'd3, 3'd4};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Round-robin search over pending pairs, starting just after the last grant.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= 10; k++) begin
      cand = {1'b0, last_grant} + 5'(k);
      if (cand >= 5'd10) cand = cand - 5'd10;
      if (!grant_found && pending[cand[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[3:0];
      end
    end
  end

  // Completion/abort decode and the pending-set update for this edge.
  always_comb begin
    timeout_hit = (state == ST_REQ) && !resolveAck && (wait_cnt >= WAIT_LAST);
    req_done    = (state == ST_REQ) && (resolveAck || timeout_hit);
    settle_done = (settle_cnt >= SETTLE_LAST);
    clear_mask  = req_done ? (10'd1 << pairIdx) : 10'd0;
    if (startOfFrame)
      pending_next = colVec;
    else
      pending_next = (pending | (colVec & ~servedMask)) & ~clear_mask;
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetN) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a frame boundary overrides everything else.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (pending != 10'd0) state_next = ST_REQ;
      ST_REQ:    if (req_done)         state_next = ST_SETTLE;
      ST_SETTLE: if (settle_done)      state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
    if (startOfFrame) state_next = ST_IDLE;
  end

  // Outputs decoded directly from the state register.
  always_comb begin
    resolveReq = (state == ST_REQ);
    busy       = (state != ST_IDLE);
  end

  // Pending/served bookkeeping, grant latch, counters and sticky error.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending      <= '0;
      servedMask   <= '0;
      pendingCount <= '0;
      last_grant   <= 4'd9;
      pairIdx      <= '0;
      ballA        <= '0;
      ballB        <= '0;
      timeoutErr   <= 1'b0;
      wait_cnt     <= '0;
      settle_cnt   <= '0;
    end else begin
      pending      <= pending_next;
      pendingCount <= popcount10(pending_next);
      if (startOfFrame) begin
        servedMask <= '0;
        wait_cnt   <= '0;
        settle_cnt <= '0;
      end else begin
        servedMask <= servedMask | clear_mask;
        if (req_done) last_grant <= pairIdx;
        if (timeout_hit) timeoutErr <= 1'b1;
        if (state == ST_IDLE && grant_found) begin
          pairIdx          <= grant_idx;
          {ballA, ballB}   <= pair_balls(grant_idx);
        end
        if (state == ST_REQ && !req_done) wait_cnt <= wait_cnt + WAIT_W'(1);
        else                              wait_cnt <= '0;
        if (state == ST_SETTLE && !settle_done) settle_cnt <= settle_cnt + SETTLE_W'(1);
        else                                    settle_cnt <= '0;
      end
    end
  end

endmodule
